// File: rtl/arbiter_rr_burst.sv
// N-client memory arbiter: fixed-priority or round-robin grant, write-burst locking, read return by id.
// Optional per-client grant counters are built when ARB_STATS_EN is defined.
module arbiter_rr_burst #(
   parameter int AN    = 24,
   parameter int DN    = 16,
   parameter int IN    = 2,
   parameter int N     = 4,
   parameter int BURST = 8,
   parameter int MODE  = 0
) (
   input  logic            clkSYS,
   input  logic            n_reset,
   input  logic [N-1:0]    req,
   input  logic [N-1:0]    wr,
   input  logic [N*AN-1:0] addr,
   input  logic [N*DN-1:0] data,
   output logic [N-1:0]    ack,
   output logic [N-1:0]    valid,
   output logic [DN-1:0]   rdata,
   output logic            mem_req,
   output logic            mem_wr,
   output logic [AN-1:0]   mem_addr,
   output logic [DN-1:0]   mem_data,
   output logic [IN-1:0]   mem_id,
   input  logic            mem_ack,
   input  logic            mem_valid,
   input  logic [DN-1:0]   mem_rdata,
   input  logic [IN-1:0]   mem_rid,
   output logic [N*16-1:0] grant_cnt
);

   localparam int GW = (N > 1) ? $clog2(N) : 1;
   localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state, state_nx;
   logic [GW-1:0]   g, g_nx, rr_ptr, rr_nx, winner, g_inc;
   logic [BW-1:0]   beat, beat_nx;
   logic            any_req;
   logic [N-1:0]    valid_nx;

   assign any_req = |req;
   assign g_inc   = (g == GW'(N-1)) ? '0 : g + 1'b1;

   // Winner search starts at rr_ptr in round-robin mode, at index 0 otherwise.
   always_comb begin : arbitrate
      int unsigned idx;
      logic        found;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int unsigned k = 0; k < N; k++) begin
         if (MODE == 1) idx = (32'(rr_ptr) + k) % N;
         else           idx = k;
         if (!found && req[idx]) begin
            winner = GW'(idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      g_nx     = g;
      beat_nx  = beat;
      rr_nx    = rr_ptr;
      ack      = '0;
      mem_req  = 1'b0;
      mem_wr   = 1'b0;
      mem_addr = '0;
      mem_data = '0;
      mem_id   = '0;
      case (state)
         IDLE: begin
            if (any_req) begin
               g_nx     = winner;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            mem_req  = req[g];
            mem_wr   = wr[g];
            mem_addr = addr[32'(g)*AN +: AN];
            mem_data = data[32'(g)*DN +: DN];
            mem_id   = IN'(g);
            ack[g]   = mem_req & mem_ack;
            if (!req[g]) begin
               state_nx = IDLE;
               beat_nx  = '0;
               rr_nx    = g_inc;
            end else if (mem_ack) begin
               if (!wr[g] || beat == BW'(BURST-1)) begin
                  state_nx = IDLE;
                  beat_nx  = '0;
                  rr_nx    = g_inc;
               end else begin
                  beat_nx = beat + 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         state  <= IDLE;
         g      <= '0;
         beat   <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nx;
         g      <= g_nx;
         beat   <= beat_nx;
         rr_ptr <= rr_nx;
      end
   end

   // Read return is independent of the grant state; ids beyond N match no client.
   always_comb begin
      valid_nx = '0;
      for (int unsigned i = 0; i < N; i++)
         valid_nx[i] = mem_valid && (32'(mem_rid) == i);
   end

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         valid <= '0;
         rdata <= '0;
      end else begin
         valid <= valid_nx;
         if (mem_valid) rdata <= mem_rdata;
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] cnt [N];

   always_ff @(posedge clkSYS or negedge n_reset) begin
      if (!n_reset) begin
         for (int unsigned i = 0; i < N; i++) cnt[i] <= '0;
      end else if (state == IDLE && any_req && cnt[winner] != 16'hffff) begin
         cnt[winner] <= cnt[winner] + 1'b1;
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int unsigned i = 0; i < N; i++) grant_cnt[i*16 +: 16] = cnt[i];
   end
`else
   assign grant_cnt = '0;
`endif

endmodule
